reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of ROB entries; it SHALL be a power of 2 and at least 4.
REQ-002 SHALL have parameter WIDTH, default 2, meaning the number of allocate lanes and the number of retire lanes.
REQ-003 SHALL have parameter N_CMPL, default 3, meaning the number of completion ports (one per FU).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_alloc_valid[WIDTH], input, 1 bit each: allocate request per lane.
REQ-007 SHALL have port i_alloc_row[WIDTH], input, rob_row_struct: per-lane has_dest, areg (5), preg, old_preg, pc (word).
REQ-008 SHALL have port o_alloc_ready, output, 1 bit: high when free entries >= WIDTH.
REQ-009 SHALL have port o_alloc_idx[WIDTH], output, IDX_W = log2(DEPTH): tag assigned per lane.
REQ-010 SHALL have port i_cmpl_valid[N_CMPL], input, 1 bit each: completion strobe.
REQ-011 SHALL have port i_cmpl_idx[N_CMPL], input, IDX_W: tag being completed.
REQ-012 SHALL have port i_cmpl_exc[N_CMPL], input, 1 bit each: completing instruction faulted.
REQ-013 SHALL have port o_retire_valid[WIDTH], output, 1 bit each: retire per lane.
REQ-014 SHALL have port o_retire_row[WIDTH], output, rob_row_struct: retiring entry contents (old_preg goes to the free list).
REQ-015 SHALL have port o_exc, output, 1 bit: a faulting entry is at head and retires this cycle.
REQ-016 SHALL have port o_exc_pc, output, word: pc of the faulting entry.
REQ-017 SHALL have port o_count, output, IDX_W+1: occupied entries.
REQ-018 SHALL have port i_flush, input, 1 bit: discard all entries.

Function
REQ-019 SHALL implement the storage as a circular buffer with head/tail pointers of IDX_W+1 bits, where the MSB is the wrap bit; full is equal index with differing wrap bit.
REQ-020 SHALL, when o_alloc_ready is high, give valid lanes consecutive entries from tail in lane order, skipping invalid lanes; tail SHALL advance by the number of valid lanes.
REQ-021 SHALL drive o_alloc_idx combinationally from tail: lane k receives tail + (number of valid lanes below k).
REQ-022 SHALL ignore allocate lanes while o_alloc_ready is low; the requester holds them.
REQ-023 SHALL, on a completion strobe, set the entry's done bit at the next edge and OR in its exc bit; completion of an invalid entry SHALL be ignored.
REQ-024 SHALL give an entry completed at edge t a retire opportunity from cycle t+1 at the earliest; completion in the same cycle as retire-eligibility evaluation SHALL NOT bypass.
REQ-025 SHALL assert retire lane k when entries head..head+k are all valid and done and none of them has exc set; retire outputs are combinational from registered state only.
REQ-026 SHALL, when the done head entry has exc set, assert o_exc and o_exc_pc with all o_retire_valid low; at the next edge the ROB SHALL flush itself.
REQ-027 SHALL update o_count at each edge as count + allocated - retired; simultaneous allocate and retire SHALL be legal, including when full.
REQ-028 SHALL, on i_flush (or a self-flush), clear all valid/done/exc bits and zero head, tail and count; flush SHALL take priority over same-cycle allocate, complete and retire.

Reset
REQ-029 SHALL, on i_rst, produce the same state as a flush; o_alloc_ready = 1, o_count = 0, all o_retire_valid = 0, o_exc = 0, o_exc_pc = 0.
REQ-030 SHALL let i_rst asserted mid-operation override all inputs in that cycle.

Structure
REQ-031 SHALL define rob_row_struct, the ROB entry state struct and default DEPTH/WIDTH constants in package Types.
REQ-032 SHALL implement one sub-module, rob_retire_select: a combinational in-order prefix of done-and-no-exc over WIDTH entries from head, returning retire mask and exception flag.

Verification (DEPTH=16, WIDTH=2, N_CMPL=3)
REQ-033 Reset then allocate two lanes -> tags 0,1; o_count=2 next cycle; no retire.
REQ-034 Allocate tags 0..3, complete 3,2,1 over three cycles -> no retire; complete 0 -> next cycle retire lanes 0,1 = tags 0,1, following cycle tags 2,3; count reaches 0.
REQ-035 Allocate lane 1 only -> tag = tail; fill to 15 entries -> o_alloc_ready=0; a 2-lane request is ignored and tail is unchanged.
REQ-036 Fill 16 entries (allocate 14, then 2), complete head two, then allocate two in the retire cycle -> count stays 16, tail wraps to index 2 with wrap bit toggled.
REQ-037 Tags 5,6 at head, 6 completes with exc and 5 completes normally -> 5 retires; next cycle o_exc=1 with pc of 6 and no retire_valid; next cycle count=0.
REQ-038 i_flush together with allocate and complete on 3 ports -> next cycle count=0, head=tail=0; i_rst mid-fill gives the same result.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry payload, entry status bits and
// default geometry.
package Types;

    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_WIDTH  = 2;
    localparam int DEFAULT_N_CMPL = 3;
    localparam int AREG_W         = 5;
    localparam int PREG_W         = 6;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic              has_dest;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [PREG_W-1:0] old_preg;
        word_t             pc;
    } rob_row_struct;

    typedef struct packed {
        logic valid;
        logic done;
        logic exc;
    } rob_state_struct;

    localparam rob_state_struct STATE_ALLOC = '{valid: 1'b1, done: 1'b0, exc: 1'b0};

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// In-order retire window: a lane may retire only if it and every older lane
// in the window are valid, done and fault-free.
module rob_retire_select
    import Types::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  rob_state_struct win         [WIDTH],
    output logic            retire_mask [WIDTH],
    output logic            exc
);

    logic ok;

    // NOTE: blocking assignments inside always_comb; ok is a running prefix
    // that each iteration must see updated immediately.
    always_comb begin
        ok = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            ok             = ok & win[k].valid & win[k].done & ~win[k].exc;
            retire_mask[k] = ok;
        end
        exc = win[0].valid & win[0].done & win[0].exc;
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: multi-lane in-order allocate and retire,
// out-of-order completion, self-flush when a faulting entry reaches head.
module reorder_buffer
    import Types::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int N_CMPL = DEFAULT_N_CMPL
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_alloc_valid  [WIDTH],
    input  rob_row_struct            i_alloc_row    [WIDTH],
    output logic                     o_alloc_ready,
    output logic [$clog2(DEPTH)-1:0] o_alloc_idx    [WIDTH],
    input  logic                     i_cmpl_valid   [N_CMPL],
    input  logic [$clog2(DEPTH)-1:0] i_cmpl_idx     [N_CMPL],
    input  logic                     i_cmpl_exc     [N_CMPL],
    output logic                     o_retire_valid [WIDTH],
    output rob_row_struct            o_retire_row   [WIDTH],
    output logic                     o_exc,
    output word_t                    o_exc_pc,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic                     i_flush
);

    localparam int IDX_W = $clog2(DEPTH);
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   ptr_t;

    ptr_t            head, tail;
    idx_t            head_idx, tail_idx;
    rob_state_struct state [DEPTH];
    rob_row_struct   rows  [DEPTH];

    idx_t            win_idx     [WIDTH];
    rob_state_struct win_state   [WIDTH];
    logic            retire_mask [WIDTH];
    logic            exc_flag;
    ptr_t            n_retire, n_alloc;
    logic [DEPTH-1:0] cmpl_done, cmpl_exc, retire_clr, alloc_set;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign o_count  = tail - head;

    always_comb begin
        n_retire = '0;
        for (int k = 0; k < WIDTH; k++) begin
            win_idx[k]        = head_idx + idx_t'(k);
            win_state[k]      = state[win_idx[k]];
            o_retire_row[k]   = rows[win_idx[k]];
            o_retire_valid[k] = retire_mask[k];
            if (retire_mask[k]) n_retire = n_retire + ptr_t'(1);
        end
    end

    rob_retire_select #(.WIDTH(WIDTH)) u_select (
        .win         (win_state),
        .retire_mask (retire_mask),
        .exc         (exc_flag)
    );

    assign o_exc    = exc_flag;
    assign o_exc_pc = exc_flag ? rows[head_idx].pc : '0;

    // Slots vacated by this cycle's retirement count as free, so a full ROB
    // can still accept a group while it drains.
    assign o_alloc_ready = (int'(DEPTH) - int'(o_count) + int'(n_retire)) >= WIDTH;

    always_comb begin
        n_alloc = '0;
        for (int k = 0; k < WIDTH; k++) begin
            o_alloc_idx[k] = tail_idx + n_alloc[IDX_W-1:0];
            if (i_alloc_valid[k]) n_alloc = n_alloc + ptr_t'(1);
        end
    end

    // NOTE: every per-entry strobe gets its default before the loops so the
    // conditional writes below cannot infer latches.
    always_comb begin
        cmpl_done  = '0;
        cmpl_exc   = '0;
        retire_clr = '0;
        alloc_set  = '0;
        for (int c = 0; c < N_CMPL; c++) begin
            if (i_cmpl_valid[c]) begin
                cmpl_done[i_cmpl_idx[c]] = 1'b1;
                cmpl_exc[i_cmpl_idx[c]]  = cmpl_exc[i_cmpl_idx[c]] | i_cmpl_exc[c];
            end
        end
        for (int k = 0; k < WIDTH; k++) begin
            if (retire_mask[k]) retire_clr[win_idx[k]] = 1'b1;
            if (o_alloc_ready && i_alloc_valid[k]) alloc_set[o_alloc_idx[k]] = 1'b1;
        end
    end

    // Reallocation of a slot retiring in the same cycle wins over its clear.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || exc_flag) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) state[i] <= '0;
        end else begin
            head <= head + n_retire;
            tail <= tail + (o_alloc_ready ? n_alloc : '0);
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_set[i]) begin
                    state[i] <= STATE_ALLOC;
                end else if (retire_clr[i]) begin
                    state[i] <= '0;
                end else if (state[i].valid && cmpl_done[i]) begin
                    state[i].done <= 1'b1;
                    state[i].exc  <= state[i].exc | cmpl_exc[i];
                end
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; its contents are only
    // observed through entries whose valid bit is set.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (o_alloc_ready && i_alloc_valid[k]) rows[o_alloc_idx[k]] <= i_alloc_row[k];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_reorder_buffer;
    import Types::*;

    localparam int DEPTH  = 16;
    localparam int WIDTH  = 2;
    localparam int N_CMPL = 3;
    localparam int IDX_W  = 4;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_alloc_valid  [WIDTH];
    rob_row_struct      i_alloc_row    [WIDTH];
    logic               o_alloc_ready;
    logic [IDX_W-1:0]   o_alloc_idx    [WIDTH];
    logic               i_cmpl_valid   [N_CMPL];
    logic [IDX_W-1:0]   i_cmpl_idx     [N_CMPL];
    logic               i_cmpl_exc     [N_CMPL];
    logic               o_retire_valid [WIDTH];
    rob_row_struct      o_retire_row   [WIDTH];
    logic               o_exc;
    word_t              o_exc_pc;
    logic [IDX_W:0]     o_count;
    logic               i_flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            tag;
        rob_row_struct row;
        bit            done;
        bit            exc;
    } m_entry_t;

    m_entry_t mq[$];
    int       m_tail;

    reorder_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .N_CMPL(N_CMPL)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_alloc_valid  (i_alloc_valid),
        .i_alloc_row    (i_alloc_row),
        .o_alloc_ready  (o_alloc_ready),
        .o_alloc_idx    (o_alloc_idx),
        .i_cmpl_valid   (i_cmpl_valid),
        .i_cmpl_idx     (i_cmpl_idx),
        .i_cmpl_exc     (i_cmpl_exc),
        .o_retire_valid (o_retire_valid),
        .o_retire_row   (o_retire_row),
        .o_exc          (o_exc),
        .o_exc_pc       (o_exc_pc),
        .o_count        (o_count),
        .i_flush        (i_flush)
    );

    always #5 i_clk = ~i_clk;

    function automatic rob_row_struct rand_row();
        rob_row_struct r;
        r.has_dest = 1'($urandom);
        r.areg     = AREG_W'($urandom);
        r.preg     = PREG_W'($urandom);
        r.old_preg = PREG_W'($urandom);
        r.pc       = $urandom;
        return r;
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < WIDTH; k++) begin
            i_alloc_valid[k] = 1'b0;
            i_alloc_row[k]   = '0;
        end
        for (int c = 0; c < N_CMPL; c++) begin
            i_cmpl_valid[c] = 1'b0;
            i_cmpl_idx[c]   = '0;
            i_cmpl_exc[c]   = 1'b0;
        end
        i_flush = 1'b0;
    endtask

    task automatic set_alloc(input logic v0, input logic v1);
        i_alloc_valid[0] = v0;
        i_alloc_valid[1] = v1;
        for (int k = 0; k < WIDTH; k++) i_alloc_row[k] = rand_row();
    endtask

    task automatic set_cmpl(input int p, input int idx, input logic exc);
        i_cmpl_valid[p] = 1'b1;
        i_cmpl_idx[p]   = IDX_W'(idx);
        i_cmpl_exc[p]   = exc;
    endtask

    task automatic reset_dut();
        clear_inputs();
        set_alloc(1'b1, 1'b1);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        clear_inputs();
        mq.delete();
        m_tail = 0;
        #1;
    endtask

    // One clock: compare DUT outputs with the model at the falling edge,
    // then advance the model by the ROB rules at the rising edge.
    task automatic tick();
        int nret;
        bit mexc, mready;
        int off;
        logic [IDX_W-1:0] e_idx;
        word_t e_pc;
        nret = 0;
        while (nret < WIDTH && nret < mq.size() && mq[nret].done && !mq[nret].exc) nret++;
        mexc   = (mq.size() > 0) && mq[0].done && mq[0].exc;
        mready = (DEPTH - mq.size() + nret) >= WIDTH;
        e_pc   = mexc ? mq[0].row.pc : 32'h0;
        @(negedge i_clk);
        checks++;
        if (int'(o_count) != mq.size()) begin
            errors++; $display("FAIL count got %0d want %0d", o_count, mq.size());
        end
        checks++;
        if (o_alloc_ready !== mready) begin
            errors++; $display("FAIL alloc_ready got %b want %b", o_alloc_ready, mready);
        end
        checks++;
        if (o_exc !== mexc || o_exc_pc !== e_pc) begin
            errors++; $display("FAIL exc got %b/%h want %b/%h", o_exc, o_exc_pc, mexc, e_pc);
        end
        off = 0;
        for (int k = 0; k < WIDTH; k++) begin
            checks++;
            if (o_retire_valid[k] !== (k < nret)) begin
                errors++; $display("FAIL retire_valid[%0d] got %b want %b", k, o_retire_valid[k], k < nret);
            end else if (k < nret) begin
                checks++;
                if (o_retire_row[k] !== mq[k].row) begin
                    errors++; $display("FAIL retire_row[%0d] got %h want %h", k, o_retire_row[k], mq[k].row);
                end
            end
            if (i_alloc_valid[k]) begin
                e_idx = IDX_W'((m_tail + off) % DEPTH);
                off++;
                checks++;
                if (o_alloc_idx[k] !== e_idx) begin
                    errors++; $display("FAIL alloc_idx[%0d] got %0d want %0d", k, o_alloc_idx[k], e_idx);
                end
            end
        end
        @(posedge i_clk);
        if (i_rst || i_flush || mexc) begin
            mq.delete();
            m_tail = 0;
        end else begin
            for (int c = 0; c < N_CMPL; c++)
                if (i_cmpl_valid[c])
                    foreach (mq[j])
                        if (mq[j].tag == int'(i_cmpl_idx[c])) begin
                            mq[j].done = 1'b1;
                            mq[j].exc  = mq[j].exc | i_cmpl_exc[c];
                        end
            repeat (nret) void'(mq.pop_front());
            if (mready)
                for (int k = 0; k < WIDTH; k++)
                    if (i_alloc_valid[k]) begin
                        mq.push_back('{tag: m_tail % DEPTH, row: i_alloc_row[k], done: 1'b0, exc: 1'b0});
                        m_tail++;
                    end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (o_count !== 5'd0 || o_alloc_ready !== 1'b1) begin
            errors++; $display("FAIL reset_count_ready got %0d/%b want 0/1", o_count, o_alloc_ready);
        end
        checks++;
        if (o_retire_valid[0] !== 1'b0 || o_retire_valid[1] !== 1'b0 || o_exc !== 1'b0 || o_exc_pc !== 32'h0) begin
            errors++; $display("FAIL reset_outputs got rv=%b%b exc=%b pc=%h want 00/0/0",
                               o_retire_valid[1], o_retire_valid[0], o_exc, o_exc_pc);
        end
    endtask

    task automatic test_alloc_two();
        reset_dut();
        set_alloc(1'b1, 1'b1);
        #1;
        checks++;
        if (o_alloc_idx[0] !== 4'd0 || o_alloc_idx[1] !== 4'd1) begin
            errors++; $display("FAIL alloc_two_tags got %0d,%0d want 0,1", o_alloc_idx[0], o_alloc_idx[1]);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (o_count !== 5'd2 || o_retire_valid[0] !== 1'b0) begin
            errors++; $display("FAIL alloc_two_count got %0d rv=%b want 2 rv=0", o_count, o_retire_valid[0]);
        end
        tick();
    endtask

    task automatic test_inorder_retire();
        word_t pc [4];
        reset_dut();
        set_alloc(1'b1, 1'b1); pc[0] = i_alloc_row[0].pc; pc[1] = i_alloc_row[1].pc; tick();
        set_alloc(1'b1, 1'b1); pc[2] = i_alloc_row[0].pc; pc[3] = i_alloc_row[1].pc; tick();
        for (int t = 3; t >= 0; t--) begin
            clear_inputs();
            set_cmpl(0, t, 1'b0);
            tick();
            if (t > 0) begin
                checks++;
                if (o_retire_valid[0] !== 1'b0) begin
                    errors++; $display("FAIL early_retire after cmpl %0d got 1 want 0", t);
                end
            end
        end
        clear_inputs();
        checks++;
        if (o_retire_valid[0] !== 1'b1 || o_retire_valid[1] !== 1'b1 ||
            o_retire_row[0].pc !== pc[0] || o_retire_row[1].pc !== pc[1]) begin
            errors++; $display("FAIL retire_01 got %b%b %h %h want 11 %h %h", o_retire_valid[1], o_retire_valid[0],
                               o_retire_row[0].pc, o_retire_row[1].pc, pc[0], pc[1]);
        end
        tick();
        checks++;
        if (o_retire_valid[0] !== 1'b1 || o_retire_valid[1] !== 1'b1 ||
            o_retire_row[0].pc !== pc[2] || o_retire_row[1].pc !== pc[3]) begin
            errors++; $display("FAIL retire_23 got %h %h want %h %h", o_retire_row[0].pc, o_retire_row[1].pc, pc[2], pc[3]);
        end
        tick();
        checks++;
        if (o_count !== 5'd0) begin
            errors++; $display("FAIL drain_count got %0d want 0", o_count);
        end
    endtask

    task automatic test_ready_full();
        reset_dut();
        set_alloc(1'b0, 1'b1);
        #1;
        checks++;
        if (o_alloc_idx[1] !== 4'd0) begin
            errors++; $display("FAIL lane1_only_tag got %0d want 0", o_alloc_idx[1]);
        end
        tick();
        repeat (7) begin set_alloc(1'b1, 1'b1); tick(); end
        clear_inputs();
        #1;
        checks++;
        if (o_count !== 5'd15 || o_alloc_ready !== 1'b0) begin
            errors++; $display("FAIL fifteen got count=%0d ready=%b want 15/0", o_count, o_alloc_ready);
        end
        set_alloc(1'b1, 1'b1);
        tick();
        checks++;
        if (o_count !== 5'd15 || o_alloc_idx[0] !== 4'd15) begin
            errors++; $display("FAIL ignored_alloc got count=%0d idx=%0d want 15/15", o_count, o_alloc_idx[0]);
        end
        clear_inputs();
    endtask

    task automatic test_full_wrap();
        reset_dut();
        repeat (7) begin set_alloc(1'b1, 1'b1); tick(); end
        set_alloc(1'b1, 1'b1); tick();
        clear_inputs();
        #1;
        checks++;
        if (o_count !== 5'd16 || o_alloc_ready !== 1'b0) begin
            errors++; $display("FAIL full got count=%0d ready=%b want 16/0", o_count, o_alloc_ready);
        end
        set_cmpl(0, 0, 1'b0);
        set_cmpl(1, 1, 1'b0);
        tick();
        clear_inputs();
        set_alloc(1'b1, 1'b1);
        #1;
        checks++;
        if (o_alloc_ready !== 1'b1 || o_alloc_idx[0] !== 4'd0 || o_alloc_idx[1] !== 4'd1) begin
            errors++; $display("FAIL full_retire_alloc got ready=%b idx=%0d,%0d want 1 0,1",
                               o_alloc_ready, o_alloc_idx[0], o_alloc_idx[1]);
        end
        tick();
        set_alloc(1'b1, 1'b1);
        #1;
        checks++;
        if (o_count !== 5'd16 || o_alloc_idx[0] !== 4'd2 || o_alloc_ready !== 1'b0) begin
            errors++; $display("FAIL wrap got count=%0d tail_idx=%0d ready=%b want 16/2/0",
                               o_count, o_alloc_idx[0], o_alloc_ready);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_exception();
        word_t pc5, pc6;
        reset_dut();
        set_alloc(1'b1, 1'b1); tick();
        set_alloc(1'b1, 1'b1); tick();
        set_alloc(1'b1, 1'b0); tick();
        clear_inputs();
        set_cmpl(0, 0, 1'b0); set_cmpl(1, 1, 1'b0); set_cmpl(2, 2, 1'b0); tick();
        clear_inputs();
        set_cmpl(0, 3, 1'b0); set_cmpl(1, 4, 1'b0); tick();
        clear_inputs();
        repeat (3) tick();
        set_alloc(1'b1, 1'b1);
        pc5 = i_alloc_row[0].pc;
        pc6 = i_alloc_row[1].pc;
        #1;
        checks++;
        if (o_count !== 5'd0 || o_alloc_idx[0] !== 4'd5) begin
            errors++; $display("FAIL exc_setup got count=%0d tag=%0d want 0/5", o_count, o_alloc_idx[0]);
        end
        tick();
        clear_inputs();
        set_cmpl(0, 6, 1'b1);
        set_cmpl(1, 5, 1'b0);
        tick();
        clear_inputs();
        checks++;
        if (o_retire_valid[0] !== 1'b1 || o_retire_valid[1] !== 1'b0 || o_retire_row[0].pc !== pc5 || o_exc !== 1'b0) begin
            errors++; $display("FAIL exc_retire5 got rv=%b%b pc=%h exc=%b want 01 %h 0",
                               o_retire_valid[1], o_retire_valid[0], o_retire_row[0].pc, o_exc, pc5);
        end
        tick();
        checks++;
        if (o_exc !== 1'b1 || o_exc_pc !== pc6 || o_retire_valid[0] !== 1'b0 || o_retire_valid[1] !== 1'b0) begin
            errors++; $display("FAIL exc_head got exc=%b pc=%h rv=%b%b want 1 %h 00",
                               o_exc, o_exc_pc, o_retire_valid[1], o_retire_valid[0], pc6);
        end
        tick();
        checks++;
        if (o_count !== 5'd0 || o_exc !== 1'b0) begin
            errors++; $display("FAIL exc_flush got count=%0d exc=%b want 0/0", o_count, o_exc);
        end
    endtask

    task automatic test_flush_and_reset();
        reset_dut();
        repeat (3) begin set_alloc(1'b1, 1'b1); tick(); end
        set_alloc(1'b1, 1'b1);
        set_cmpl(0, 0, 1'b0); set_cmpl(1, 1, 1'b1); set_cmpl(2, 2, 1'b0);
        i_flush = 1'b1;
        tick();
        clear_inputs();
        set_alloc(1'b1, 1'b0);
        #1;
        checks++;
        if (o_count !== 5'd0 || o_alloc_idx[0] !== 4'd0) begin
            errors++; $display("FAIL flush got count=%0d tail=%0d want 0/0", o_count, o_alloc_idx[0]);
        end
        tick();
        repeat (2) begin set_alloc(1'b1, 1'b1); tick(); end
        set_alloc(1'b1, 1'b1);
        set_cmpl(0, 0, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        clear_inputs();
        set_alloc(1'b1, 1'b0);
        #1;
        checks++;
        if (o_count !== 5'd0 || o_alloc_idx[0] !== 4'd0) begin
            errors++; $display("FAIL midfill_reset got count=%0d tail=%0d want 0/0", o_count, o_alloc_idx[0]);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        reset_dut();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            clear_inputs();
            set_alloc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            for (int c = 0; c < N_CMPL; c++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if (mq.size() > 0)
                        set_cmpl(c, mq[$urandom_range(0, mq.size() - 1)].tag, 1'($urandom_range(0, 29) == 0));
                    else
                        set_cmpl(c, $urandom_range(0, DEPTH - 1), 1'b0);
                end
            end
            i_flush = 1'($urandom_range(0, 99) == 0);
            i_rst   = 1'($urandom_range(0, 299) == 0);
            tick();
            i_rst = 1'b0;
        end
        clear_inputs();
    endtask

    initial begin
        i_rst = 1'b0;
        clear_inputs();
        m_tail = 0;
        test_reset();
        test_alloc_two();
        test_inorder_retire();
        test_ready_full();
        test_full_wrap();
        test_exception();
        test_flush_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
